// File: rtl/tilemap_pkg.sv
// Shared encodings, slot timing and FSM type for the tilemap line fetcher.
package tilemap_pkg;
  localparam int NUM_LAYERS = 2;
  localparam int LA = 0;
  localparam int LB = 1;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [2:0] A_REQ      = 3'd3;
  localparam logic [2:0] A_DL       = 3'd6;
  localparam logic [2:0] B_REQ      = 3'd7;
  localparam logic [2:0] B_DL       = 3'd2;
  localparam logic [2:0] A_LOAD_OFS = 3'd0;
  localparam logic [2:0] B_LOAD_OFS = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_A = 2'd1,
    REQ_B = 2'd2
  } fsm_t;
endpackage

// File: rtl/tilemap_mode_gen.sv
// Per-layer shift-register mode and flip flag; loads at (load offset + fine scroll) mod 8.
module tilemap_mode_gen
  import tilemap_pkg::*;
(
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_RST_n,
  input  logic       i_CE,
  input  logic [2:0] i_HCNT,
  input  logic       i_HBLANK_n,
  input  logic [2:0] i_LOAD_OFS,
  input  logic [2:0] i_FSCX,
  input  logic       i_WORD_HF,
  output logic [1:0] o_MODE,
  output logic       o_FF
);
  logic [2:0] ld_px;
  assign ld_px = i_LOAD_OFS + i_FSCX;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      o_MODE <= MODE_HOLD;
      o_FF   <= 1'b0;
    end else if (i_CE) begin
      if (!i_HBLANK_n) begin
        o_MODE <= MODE_HOLD;
      end else if (i_HCNT == ld_px) begin
        o_MODE <= MODE_LOAD;
        o_FF   <= i_WORD_HF;
      end else begin
        o_MODE <= o_FF ? MODE_SHR : MODE_SHL;
      end
    end
  end
endmodule

// File: rtl/tilemap_line_fetcher.sv
// Shared-port line-word fetcher for TM-A/TM-B: request FSM, fetch buffers, deadline presentation.
module tilemap_line_fetcher
  import tilemap_pkg::*;
#(
  parameter int CODE_W = 11
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_RST_n,
  input  logic                i_EMU_CLK6MPCEN_n,
  input  logic [2:0]          i_HCNT,
  input  logic                i_HBLANK_n,
  input  logic [CODE_W-1:0]   i_A_CODE,
  input  logic [CODE_W-1:0]   i_B_CODE,
  input  logic [2:0]          i_A_ROW,
  input  logic [2:0]          i_B_ROW,
  input  logic                i_A_HFLIP,
  input  logic                i_B_HFLIP,
  input  logic                i_A_VFLIP,
  input  logic                i_B_VFLIP,
  input  logic [2:0]          i_A_FSCX,
  input  logic [2:0]          i_B_FSCX,
  output logic                o_MEM_REQ,
  output logic [CODE_W+2:0]   o_MEM_ADDR,
  input  logic                i_MEM_ACK,
  input  logic [31:0]         i_MEM_DATA,
  output logic [31:0]         o_GFXDATA,
  output logic [1:0]          o_A_MODE,
  output logic [1:0]          o_B_MODE,
  output logic                o_AFF,
  output logic                o_BFF,
  output logic                o_MISS
);
  logic ce, start_a, start_b, dl_a, dl_b;
  assign ce      = ~i_EMU_CLK6MPCEN_n;
  assign start_a = ce && i_HBLANK_n && (i_HCNT == A_REQ);
  assign start_b = ce && i_HBLANK_n && (i_HCNT == B_REQ);
  assign dl_a    = ce && (i_HCNT == A_DL);
  assign dl_b    = ce && (i_HCNT == B_DL);

  fsm_t state_q, state_d;
  logic take_ack, miss_now, ack_lyr;

  logic [CODE_W+2:0]                addr_q;
  logic                             req_hf_q;
  logic [NUM_LAYERS-1:0][31:0]      buf_q;
  logic [NUM_LAYERS-1:0]            buf_hf_q, vld_q, pres_hf_q;
  logic [31:0]                      gfx_q;
  logic                             miss_q;

  // Deadline beats ACK: an ACK landing on the deadline edge is a miss.
  always_comb begin
    state_d  = state_q;
    take_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_a)      state_d = REQ_A;
        else if (start_b) state_d = REQ_B;
      end
      REQ_A: begin
        if (dl_a)           state_d = IDLE;
        else if (i_MEM_ACK) begin state_d = IDLE; take_ack = 1'b1; end
      end
      REQ_B: begin
        if (dl_b)           state_d = IDLE;
        else if (i_MEM_ACK) begin state_d = IDLE; take_ack = 1'b1; end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miss_now = ((state_q == REQ_A) && dl_a) || ((state_q == REQ_B) && dl_b);
  assign ack_lyr  = (state_q == REQ_B);

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      req_hf_q  <= 1'b0;
      buf_q     <= '0;
      buf_hf_q  <= '0;
      vld_q     <= '0;
      pres_hf_q <= '0;
      gfx_q     <= '0;
      miss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == REQ_A) begin
        addr_q   <= {i_A_CODE, i_A_ROW ^ {3{i_A_VFLIP}}};
        req_hf_q <= i_A_HFLIP;
      end
      if (state_q == IDLE && state_d == REQ_B) begin
        addr_q   <= {i_B_CODE, i_B_ROW ^ {3{i_B_VFLIP}}};
        req_hf_q <= i_B_HFLIP;
      end
      if (take_ack) begin
        buf_q[ack_lyr]    <= i_MEM_DATA;
        buf_hf_q[ack_lyr] <= req_hf_q;
        vld_q[ack_lyr]    <= 1'b1;
      end
      // A missed word presents as transparent and carries no flip.
      if (dl_a) begin
        gfx_q         <= vld_q[LA] ? buf_q[LA] : 32'h0;
        pres_hf_q[LA] <= vld_q[LA] & buf_hf_q[LA];
        vld_q[LA]     <= 1'b0;
      end
      if (dl_b) begin
        gfx_q         <= vld_q[LB] ? buf_q[LB] : 32'h0;
        pres_hf_q[LB] <= vld_q[LB] & buf_hf_q[LB];
        vld_q[LB]     <= 1'b0;
      end
      if (ce) miss_q <= miss_now;
    end
  end

  assign o_MEM_REQ  = (state_q != IDLE);
  assign o_MEM_ADDR = addr_q;
  assign o_GFXDATA  = gfx_q;
  assign o_MISS     = miss_q;

  logic [NUM_LAYERS-1:0][2:0] fscx, ld_ofs;
  logic [NUM_LAYERS-1:0][1:0] mode;
  logic [NUM_LAYERS-1:0]      ff;
  assign fscx   = {i_B_FSCX, i_A_FSCX};
  assign ld_ofs = {B_LOAD_OFS, A_LOAD_OFS};

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    tilemap_mode_gen u_mode (
      .i_EMU_MCLK  (i_EMU_MCLK),
      .i_EMU_RST_n (i_EMU_RST_n),
      .i_CE        (ce),
      .i_HCNT      (i_HCNT),
      .i_HBLANK_n  (i_HBLANK_n),
      .i_LOAD_OFS  (ld_ofs[l]),
      .i_FSCX      (fscx[l]),
      .i_WORD_HF   (pres_hf_q[l]),
      .o_MODE      (mode[l]),
      .o_FF        (ff[l])
    );
  end

  assign o_A_MODE = mode[LA];
  assign o_B_MODE = mode[LB];
  assign o_AFF    = ff[LA];
  assign o_BFF    = ff[LB];
endmodule

// File: tb/tb_tilemap_line_fetcher.sv
// Directed bench: steady-state vector table plus hand sequences for flips, miss, scroll, blank, reset.
module tb_tilemap_line_fetcher;
  localparam logic [31:0] DA = 32'h12345678;
  localparam logic [31:0] DB = 32'h9ABCDEF0;
  localparam logic [13:0] AA = 14'h091C;
  localparam logic [13:0] AB = 14'h22B1;

  logic        clk = 1'b0, rst_n = 1'b0, ce_n = 1'b1, hblank_n = 1'b1;
  logic [2:0]  hcnt = 3'd0;
  logic [10:0] a_code = 11'h123, b_code = 11'h456;
  logic [2:0]  a_row = 3'd4, b_row = 3'd1, a_fscx = 3'd0, b_fscx = 3'd0;
  logic        a_hf = 1'b0, b_hf = 1'b0, a_vf = 1'b0, b_vf = 1'b0;
  logic        req, aff, bff, miss, mem_ack;
  logic [13:0] addr;
  logic [31:0] mem_data, gfx;
  logic [1:0]  am, bm;

  logic        resp_ack = 1'b0, man_ack = 1'b0, cur_tgt = 1'b0;
  logic        ack_en_a = 1'b1, ack_en_b = 1'b1;
  logic [31:0] resp_data = 32'h0, man_data = 32'hDEADBEEF;
  logic [31:0] dat_a = DA, dat_b = DB;
  int          req_age = 0;
  int          total = 0, bad = 0;

  assign mem_ack  = resp_ack | man_ack;
  assign mem_data = man_ack ? man_data : resp_data;

  tilemap_line_fetcher dut (
    .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n), .i_EMU_CLK6MPCEN_n(ce_n),
    .i_HCNT(hcnt), .i_HBLANK_n(hblank_n),
    .i_A_CODE(a_code), .i_B_CODE(b_code), .i_A_ROW(a_row), .i_B_ROW(b_row),
    .i_A_HFLIP(a_hf), .i_B_HFLIP(b_hf), .i_A_VFLIP(a_vf), .i_B_VFLIP(b_vf),
    .i_A_FSCX(a_fscx), .i_B_FSCX(b_fscx),
    .o_MEM_REQ(req), .o_MEM_ADDR(addr), .i_MEM_ACK(mem_ack), .i_MEM_DATA(mem_data),
    .o_GFXDATA(gfx), .o_A_MODE(am), .o_B_MODE(bm), .o_AFF(aff), .o_BFF(bff), .o_MISS(miss)
  );

  always #5 clk = ~clk;

  // Memory model: acks two MCLK after REQ rises, for whichever layer the slot selected.
  always @(negedge clk) begin
    if (!req || resp_ack) begin
      resp_ack = 1'b0;
      req_age  = 0;
    end else begin
      req_age++;
      if (req_age == 2 && (cur_tgt ? ack_en_b : ack_en_a)) begin
        resp_ack  = 1'b1;
        resp_data = cur_tgt ? dat_b : dat_a;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One pixel: three idle MCLKs then the CE MCLK; man_at picks an MCLK (1..4) for a manual ACK.
  task automatic px(input int h, input int man_at = 0);
    hcnt = 3'(h);
    if (h == 3) cur_tgt = 1'b0;
    else if (h == 7) cur_tgt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ce_n    = (i != 4);
      man_ack = (i == man_at);
      @(posedge clk); #1;
    end
    ce_n = 1'b1;
    man_ack = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  h;
    logic        req;
    logic [13:0] addr;
    logic [31:0] gfx;
    logic [1:0]  am;
    logic [1:0]  bm;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 14'h0, 32'h0, 2'b11, 2'b10};
    tbl[1]  = '{3'd1, 1'b0, 14'h0, 32'h0, 2'b10, 2'b10};
    tbl[2]  = '{3'd2, 1'b0, 14'h0, 32'h0, 2'b10, 2'b10};
    tbl[3]  = '{3'd3, 1'b1, AA,    32'h0, 2'b10, 2'b10};
    tbl[4]  = '{3'd4, 1'b0, 14'h0, 32'h0, 2'b10, 2'b11};
    tbl[5]  = '{3'd5, 1'b0, 14'h0, 32'h0, 2'b10, 2'b10};
    tbl[6]  = '{3'd6, 1'b0, 14'h0, DA,    2'b10, 2'b10};
    tbl[7]  = '{3'd7, 1'b1, AB,    DA,    2'b10, 2'b10};
    tbl[8]  = '{3'd0, 1'b0, 14'h0, DA,    2'b11, 2'b10};
    tbl[9]  = '{3'd1, 1'b0, 14'h0, DA,    2'b10, 2'b10};
    tbl[10] = '{3'd2, 1'b0, 14'h0, DB,    2'b10, 2'b10};
    tbl[11] = '{3'd3, 1'b1, AA,    DB,    2'b10, 2'b10};
    tbl[12] = '{3'd4, 1'b0, 14'h0, DB,    2'b10, 2'b11};
    tbl[13] = '{3'd5, 1'b0, 14'h0, DB,    2'b10, 2'b10};
    tbl[14] = '{3'd6, 1'b0, 14'h0, DA,    2'b10, 2'b10};
    tbl[15] = '{3'd7, 1'b1, AB,    DA,    2'b10, 2'b10};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'h0);   chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_gfx", gfx, 32'h0);        chk("rst_am", 32'(am), 32'h0);
    chk("rst_bm", 32'(bm), 32'h0);     chk("rst_aff", 32'(aff), 32'h0);
    chk("rst_bff", 32'(bff), 32'h0);   chk("rst_miss", 32'(miss), 32'h0);
    rst_n = 1'b1;

    // steady-state fetch/present/mode, two groups
    for (int i = 0; i < 16; i++) begin
      px(int'(tbl[i].h));
      chk($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_gfx", i), gfx, tbl[i].gfx);
      chk($sformatf("tbl%0d_am", i), 32'(am), 32'(tbl[i].am));
      chk($sformatf("tbl%0d_bm", i), 32'(bm), 32'(tbl[i].bm));
      chk($sformatf("tbl%0d_miss", i), 32'(miss), 32'h0);
    end

    // vflip row remap, hflip follows the word even if changed mid-flight
    a_code = 11'h005; a_row = 3'd2; a_vf = 1'b1; a_hf = 1'b1; dat_a = 32'h0F0F1234;
    px(0); px(1); px(2); px(3);
    chk("vf_req", 32'(req), 32'h1);
    chk("vf_addr", 32'(addr), 32'h002D);
    a_code = 11'h123; a_row = 3'd4; a_vf = 1'b0; a_hf = 1'b0;
    px(4); px(5); px(6);
    chk("vf_gfx", gfx, 32'h0F0F1234);
    px(7); px(0);
    chk("hf_load_am", 32'(am), 32'h3);
    chk("hf_aff", 32'(aff), 32'h1);
    px(1);
    chk("hf_shr_am", 32'(am), 32'h1);
    chk("hf_bff", 32'(bff), 32'h0);
    for (int h = 2; h < 8; h++) px(h);
    px(0);
    chk("hf_off_aff", 32'(aff), 32'h0);
    chk("hf_off_am", 32'(am), 32'h3);
    px(1);
    chk("hf_off_shl", 32'(am), 32'h2);

    // B never acked: miss at its deadline, ACK on deadline edge and late ACK ignored
    dat_a = 32'h55AA55AA; ack_en_b = 1'b0;
    for (int h = 2; h < 7; h++) px(h);
    px(7);
    chk("miss_req7", 32'(req), 32'h1);
    chk("miss_addr", 32'(addr), 32'(AB));
    px(0);
    chk("miss_req0", 32'(req), 32'h1);
    px(1);
    chk("miss_req1", 32'(req), 32'h1);
    chk("miss_pre", 32'(miss), 32'h0);
    px(2, 4);
    chk("miss_reqdrop", 32'(req), 32'h0);
    chk("miss_gfx", gfx, 32'h0);
    chk("miss_pulse", 32'(miss), 32'h1);
    dat_a = 32'h66CC33FF;
    px(3, 2);
    chk("miss_clr", 32'(miss), 32'h0);
    chk("late_a_req", 32'(req), 32'h1);
    chk("late_a_addr", 32'(addr), 32'(AA));
    px(4); px(5); px(6);
    chk("late_a_gfx", gfx, 32'h66CC33FF);
    ack_en_b = 1'b1;
    px(7);

    // fine scroll: B loads at (4+5)%8=1, A at 7
    a_fscx = 3'd7; b_fscx = 3'd5;
    px(0);
    chk("scx_am0", 32'(am), 32'h2);
    chk("scx_bm0", 32'(bm), 32'h2);
    px(1);
    chk("scx_bm1", 32'(bm), 32'h3);
    px(2); px(3); px(4);
    chk("scx_bm4", 32'(bm), 32'h2);
    px(5); px(6); px(7);
    chk("scx_am7", 32'(am), 32'h3);
    a_fscx = 3'd0; b_fscx = 3'd0;

    // blanking for 16 px starting at HCNT=5, release at HCNT=5
    for (int h = 0; h < 5; h++) px(h);
    hblank_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      px((5 + k) % 8);
      chk($sformatf("blk%0d_am", k), 32'(am), 32'h0);
      chk($sformatf("blk%0d_bm", k), 32'(bm), 32'h0);
      chk($sformatf("blk%0d_req", k), 32'(req), 32'h0);
    end
    hblank_n = 1'b1;
    px(5);
    chk("unblk_req5", 32'(req), 32'h0);
    chk("unblk_am5", 32'(am), 32'h2);
    px(6);
    chk("unblk_req6", 32'(req), 32'h0);
    chk("unblk_gfx6", gfx, 32'h0);
    ack_en_b = 1'b0;
    px(7);
    chk("unblk_req7", 32'(req), 32'h1);
    chk("unblk_addr7", 32'(addr), 32'(AB));

    // async reset while REQ is high
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'h0);  chk("arst_addr", 32'(addr), 32'h0);
    chk("arst_gfx", gfx, 32'h0);       chk("arst_am", 32'(am), 32'h0);
    chk("arst_bm", 32'(bm), 32'h0);    chk("arst_aff", 32'(aff), 32'h0);
    chk("arst_bff", 32'(bff), 32'h0);  chk("arst_miss", 32'(miss), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; ack_en_b = 1'b1;
    px(0);
    chk("post_req0", 32'(req), 32'h0);
    px(1);
    chk("post_req1", 32'(req), 32'h0);
    px(2);
    chk("post_req2", 32'(req), 32'h0);
    chk("post_miss2", 32'(miss), 32'h0);
    chk("post_gfx2", gfx, 32'h0);
    px(3);
    chk("post_req3", 32'(req), 32'h1);
    chk("post_addr3", 32'(addr), 32'(AA));
    px(4); px(5); px(6);
    chk("post_gfx6", gfx, 32'h66CC33FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
